// File: rtl/hazard_match_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_match_pipe_pkg
// Brief   : Shared widths, control-bundle layouts and bubble constants for
//           the E/M/W control pipeline.
// Revision: 1.0 - initial release
// ============================================================================
package hazard_match_pipe_pkg;

  localparam int DEF_RA_W   = 4;   // register address width
  localparam int DEF_PC_REG = 15;  // PC register address, never a match source
  localparam int DEF_CNT_W  = 32;  // retired-instruction counter width

  // E-stage control bundle (MSB first: RegWrite, MemToReg, PCSrc, Branch, Valid)
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic pc_src;
    logic branch;
    logic valid;
  } ctrl_e_t;

  // M/W-stage control bundle; write enables are already condition-gated here
  typedef struct packed {
    logic reg_write;
    logic pc_src;
    logic valid;
  } ctrl_mw_t;

  localparam int CTRL_E_W  = $bits(ctrl_e_t);
  localparam int CTRL_MW_W = $bits(ctrl_mw_t);

  localparam ctrl_e_t  CTRL_E_BUBBLE  = '0;
  localparam ctrl_mw_t CTRL_MW_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/hazard_match_pipe_pipe_ctrl_reg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl_reg
// Brief   : One pipeline stage register with async active-low clear and a
//           synchronous bubble-insert input.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_ctrl_reg #(
  parameter int         W      = 8,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bubble_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  // Bubble insertion takes priority over the incoming stage contents
  always_comb begin
    data_d = d_i;
    if (bubble_i) begin
      data_d = BUBBLE;
    end
  end

  // Stage register; reset discards whatever is in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule
`default_nettype wire

// File: rtl/hazard_match_pipe.sv
`default_nettype none
// ============================================================================
// Module  : hazard_match_pipe
// Brief   : E/M/W control pipeline registers, register-match signals for the
//           hazard unit, M/W write-back controls and a retired-instr counter.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_match_pipe
  import hazard_match_pipe_pkg::*;
#(
  parameter int RA_W   = DEF_RA_W,
  parameter int PC_REG = DEF_PC_REG,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  RA1D,
  input  logic [RA_W-1:0]  RA2D,
  input  logic [RA_W-1:0]  WA3D,
  input  logic             RegWriteD,
  input  logic             MemToRegD,
  input  logic             PCSrcD,
  input  logic             BranchD,
  input  logic             ValidD,
  input  logic             CondExE,
  input  logic             FlushE,
  output logic             Match_1E_M,
  output logic             Match_1E_W,
  output logic             Match_2E_M,
  output logic             Match_2E_W,
  output logic             Match_12D_E,
  output logic             MemToRegE,
  output logic             PCSrcE,
  output logic             PCSrcM,
  output logic             PCSrcW,
  output logic             BranchTakenE,
  output logic             RegWriteM,
  output logic             RegWriteW,
  output logic [RA_W-1:0]  WA3M,
  output logic [RA_W-1:0]  WA3W,
  output logic             RetiredW,
  output logic [CNT_W-1:0] RetireCnt
);

  localparam logic [RA_W-1:0] PC_ADDR = RA_W'(PC_REG);
  localparam int              E_W     = CTRL_E_W + 3 * RA_W;
  localparam int              MW_W    = CTRL_MW_W + RA_W;
  localparam logic [E_W-1:0]  E_BUBBLE  = {CTRL_E_BUBBLE, {(3 * RA_W){1'b0}}};
  localparam logic [MW_W-1:0] MW_BUBBLE = {CTRL_MW_BUBBLE, {RA_W{1'b0}}};

  // ---------------- E stage ----------------
  ctrl_e_t         ctrl_d;
  logic [E_W-1:0]  e_d;
  logic [E_W-1:0]  e_q;
  ctrl_e_t         ctrl_e_q;
  logic [RA_W-1:0] ra1_e_q;
  logic [RA_W-1:0] ra2_e_q;
  logic [RA_W-1:0] wa3_e_q;

  assign ctrl_d = {RegWriteD, MemToRegD, PCSrcD, BranchD, ValidD};
  assign e_d    = {ctrl_d, RA1D, RA2D, WA3D};

  // FlushE only acts at the clock edge, so no output sees it combinationally
  pipe_ctrl_reg #(
    .W      (E_W),
    .BUBBLE (E_BUBBLE)
  ) u_stage_e (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (FlushE),
    .d_i      (e_d),
    .q_o      (e_q)
  );

  assign {ctrl_e_q, ra1_e_q, ra2_e_q, wa3_e_q} = e_q;

  // ---------------- M stage ----------------
  ctrl_mw_t        ctrl_m_d;
  logic [MW_W-1:0] m_d;
  logic [MW_W-1:0] m_q;
  ctrl_mw_t        ctrl_m_q;
  logic [RA_W-1:0] wa3_m_q;

  // A failed condition or a bubble in E kills the write enables on entry to M
  assign ctrl_m_d.reg_write = ctrl_e_q.reg_write & CondExE & ctrl_e_q.valid;
  assign ctrl_m_d.pc_src    = ctrl_e_q.pc_src & CondExE & ctrl_e_q.valid;
  assign ctrl_m_d.valid     = ctrl_e_q.valid;
  assign m_d                = {ctrl_m_d, wa3_e_q};

  pipe_ctrl_reg #(
    .W      (MW_W),
    .BUBBLE (MW_BUBBLE)
  ) u_stage_m (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (1'b0),
    .d_i      (m_d),
    .q_o      (m_q)
  );

  assign {ctrl_m_q, wa3_m_q} = m_q;

  // ---------------- W stage ----------------
  logic [MW_W-1:0] w_q;
  ctrl_mw_t        ctrl_w_q;
  logic [RA_W-1:0] wa3_w_q;

  pipe_ctrl_reg #(
    .W      (MW_W),
    .BUBBLE (MW_BUBBLE)
  ) u_stage_w (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (1'b0),
    .d_i      (m_q),
    .q_o      (w_q)
  );

  assign {ctrl_w_q, wa3_w_q} = w_q;

  // ---------------- Register matches ----------------
  // RegWrite qualification is left to the hazard unit; only validity and the
  // PC exclusion are applied here.
  assign Match_1E_M  = (ra1_e_q == wa3_m_q) & (ra1_e_q != PC_ADDR) & ctrl_m_q.valid;
  assign Match_1E_W  = (ra1_e_q == wa3_w_q) & (ra1_e_q != PC_ADDR) & ctrl_w_q.valid;
  assign Match_2E_M  = (ra2_e_q == wa3_m_q) & (ra2_e_q != PC_ADDR) & ctrl_m_q.valid;
  assign Match_2E_W  = (ra2_e_q == wa3_w_q) & (ra2_e_q != PC_ADDR) & ctrl_w_q.valid;
  assign Match_12D_E = ((RA1D == wa3_e_q) | (RA2D == wa3_e_q)) & ctrl_e_q.valid
                       & (wa3_e_q != PC_ADDR);

  // ---------------- Stage controls ----------------
  // MemToRegE stays ungated so a load-use stall is raised even if it fails
  assign MemToRegE    = ctrl_e_q.mem_to_reg;
  assign PCSrcE       = ctrl_e_q.pc_src & CondExE & ctrl_e_q.valid;
  assign BranchTakenE = ctrl_e_q.branch & CondExE & ctrl_e_q.valid;
  assign PCSrcM       = ctrl_m_q.pc_src;
  assign RegWriteM    = ctrl_m_q.reg_write;
  assign WA3M         = wa3_m_q;
  assign PCSrcW       = ctrl_w_q.pc_src;
  assign RegWriteW    = ctrl_w_q.reg_write;
  assign WA3W         = wa3_w_q;
  assign RetiredW     = ctrl_w_q.valid;

  // ---------------- Retire counter ----------------
  logic [CNT_W-1:0] retire_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q;

  // Count each valid W instruction, sticking at all-ones instead of wrapping
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (ctrl_w_q.valid && (retire_cnt_q != {CNT_W{1'b1}})) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
  end

  // Counter register; reset drops the count without adjustment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign RetireCnt = retire_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_match_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_match_pipe
// Brief   : Directed-vector scoreboard bench for hazard_match_pipe. A 32-bit
//           and a 4-bit-counter instance share all inputs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hazard_match_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] RA1D, RA2D, WA3D;
  logic       RegWriteD, MemToRegD, PCSrcD, BranchD, ValidD, CondExE, FlushE;

  logic        m1em, m1ew, m2em, m2ew, m12de, m2re, pcse, pcsm, pcsw, bt, rwm, rww, ret;
  logic [3:0]  wa3m, wa3w;
  logic [31:0] cnt;

  logic       s_m1em, s_m1ew, s_m2em, s_m2ew, s_m12de, s_m2re, s_pcse, s_pcsm, s_pcsw;
  logic       s_bt, s_rwm, s_rww, s_ret;
  logic [3:0] s_wa3m, s_wa3w, s_cnt;

  hazard_match_pipe u_dut (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .PCSrcD(PCSrcD), .BranchD(BranchD),
    .ValidD(ValidD), .CondExE(CondExE), .FlushE(FlushE),
    .Match_1E_M(m1em), .Match_1E_W(m1ew), .Match_2E_M(m2em), .Match_2E_W(m2ew),
    .Match_12D_E(m12de), .MemToRegE(m2re), .PCSrcE(pcse), .PCSrcM(pcsm), .PCSrcW(pcsw),
    .BranchTakenE(bt), .RegWriteM(rwm), .RegWriteW(rww), .WA3M(wa3m), .WA3W(wa3w),
    .RetiredW(ret), .RetireCnt(cnt)
  );

  hazard_match_pipe #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .PCSrcD(PCSrcD), .BranchD(BranchD),
    .ValidD(ValidD), .CondExE(CondExE), .FlushE(FlushE),
    .Match_1E_M(s_m1em), .Match_1E_W(s_m1ew), .Match_2E_M(s_m2em), .Match_2E_W(s_m2ew),
    .Match_12D_E(s_m12de), .MemToRegE(s_m2re), .PCSrcE(s_pcse), .PCSrcM(s_pcsm),
    .PCSrcW(s_pcsw), .BranchTakenE(s_bt), .RegWriteM(s_rwm), .RegWriteW(s_rww),
    .WA3M(s_wa3m), .WA3W(s_wa3w), .RetiredW(s_ret), .RetireCnt(s_cnt)
  );

  typedef struct packed {
    logic m1em, m1ew, m2em, m2ew, m12de, m2re, pcse, pcsm, pcsw, bt, rwm, rww;
    logic [3:0]  wa3m;
    logic [3:0]  wa3w;
    logic        ret;
    logic [31:0] cnt;
  } exp_t;

  typedef struct packed {
    logic       rst_n;
    logic [3:0] ra1, ra2, wa3;
    logic       rw, m2r, pcs, br, vd, cond, flush;
  } vec_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  function automatic exp_t ez(input int c);
    exp_t e;
    e     = '0;
    e.cnt = 32'(c);
    return e;
  endfunction

  function automatic vec_t vz();
    vec_t v;
    v       = '0;
    v.rst_n = 1'b1;
    return v;
  endfunction

  function automatic vec_t vi(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] w,
                              input logic rw_, input logic m2r_, input logic pcs_, input logic br_);
    vec_t v;
    v     = vz();
    v.ra1 = a1; v.ra2 = a2; v.wa3 = w;
    v.rw  = rw_; v.m2r = m2r_; v.pcs = pcs_; v.br = br_;
    v.vd  = 1'b1;
    return v;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected during that cycle
  task automatic cyc(input vec_t v, input exp_t e, input string tag);
    @(posedge clk);
    #1;
    reset     = v.rst_n;
    RA1D      = v.ra1;  RA2D = v.ra2;  WA3D = v.wa3;
    RegWriteD = v.rw;   MemToRegD = v.m2r;  PCSrcD = v.pcs;  BranchD = v.br;
    ValidD    = v.vd;   CondExE = v.cond;   FlushE = v.flush;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Monitor: compare both instances whenever an expectation is pending
  exp_t  mon_e, mon_a, mon_es, mon_as;
  string mon_t;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      mon_a = {m1em, m1ew, m2em, m2ew, m12de, m2re, pcse, pcsm, pcsw, bt, rwm, rww,
               wa3m, wa3w, ret, cnt};
      total++;
      if (mon_a !== mon_e) begin
        bad++;
        $display("FAIL %s main: got %h want %h", mon_t, mon_a, mon_e);
      end
      mon_es     = mon_e;
      mon_es.cnt = (mon_e.cnt > 32'd15) ? 32'd15 : mon_e.cnt;
      mon_as = {s_m1em, s_m1ew, s_m2em, s_m2ew, s_m12de, s_m2re, s_pcse, s_pcsm, s_pcsw,
                s_bt, s_rwm, s_rww, s_wa3m, s_wa3w, s_ret, 28'd0, s_cnt};
      total++;
      if (mon_as !== mon_es) begin
        bad++;
        $display("FAIL %s sat: got %h want %h", mon_t, mon_as, mon_es);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    exp_t e;
    int   c;
    reset = 1'b0;
    RA1D = '0; RA2D = '0; WA3D = '0;
    RegWriteD = 0; MemToRegD = 0; PCSrcD = 0; BranchD = 0; ValidD = 0; CondExE = 0; FlushE = 0;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      v = vec_t'($urandom);
      v.rst_n = 1'b0;
      cyc(v, ez(0), "reset");
    end

    // ADD R1 ; SUB uses R1 ; ORR uses R1/R5
    v = vi(2, 3, 1, 1, 0, 0, 0);                   cyc(v, ez(0), "add_d");
    v = vi(1, 4, 5, 1, 0, 0, 0); v.cond = 1;
    e = ez(0); e.m12de = 1;                         cyc(v, e, "sub_d");
    v = vi(1, 5, 7, 1, 0, 0, 0); v.cond = 1;
    e = ez(0); e.m1em = 1; e.m12de = 1; e.rwm = 1; e.wa3m = 1;  cyc(v, e, "m1em");
    v = vz(); v.cond = 1;
    e = ez(0); e.m2em = 1; e.m1ew = 1; e.rwm = 1; e.wa3m = 5; e.rww = 1; e.wa3w = 1; e.ret = 1;
    cyc(v, e, "m2em_m1ew");
    v = vz();
    e = ez(1); e.rwm = 1; e.wa3m = 7; e.rww = 1; e.wa3w = 5; e.ret = 1;  cyc(v, e, "drain1");
    e = ez(2); e.rww = 1; e.wa3w = 7; e.ret = 1;    cyc(v, e, "drain2");
    cyc(v, ez(3), "cnt3");

    // LDR R2 then a user of R2, flushed in the same cycle (flush wins over ValidD)
    v = vi(3, 0, 2, 1, 1, 0, 0);                   cyc(v, ez(3), "ldr_d");
    v = vi(4, 2, 6, 1, 0, 0, 0); v.flush = 1;
    e = ez(3); e.m12de = 1; e.m2re = 1;             cyc(v, e, "ldr_use");
    v = vz();
    e = ez(3); e.wa3m = 2;                          cyc(v, e, "ldr_m_nocond");
    e = ez(3); e.wa3w = 2; e.ret = 1;               cyc(v, e, "ldr_w");
    cyc(v, ez(4), "cnt4");

    // Load to R15: no D/E match; then PC exclusion on the E-side compare
    v = vi(1, 0, 15, 1, 1, 0, 0);                  cyc(v, ez(4), "ldr15_d");
    v = vz(); v.ra1 = 15; v.ra2 = 15; v.cond = 1;
    e = ez(4); e.m2re = 1;                          cyc(v, e, "wa3e_pc");
    v = vz();
    e = ez(4); e.rwm = 1; e.wa3m = 15;              cyc(v, e, "ra_pc");
    e = ez(4); e.rww = 1; e.wa3w = 15; e.ret = 1;   cyc(v, e, "ldr15_w");
    cyc(v, ez(5), "cnt5");

    // Branch taken, then flush drops the following instr
    v = vi(0, 0, 9, 0, 0, 0, 1);                   cyc(v, ez(5), "br_d");
    v = vi(9, 9, 3, 1, 0, 0, 0); v.cond = 1; v.flush = 1;
    e = ez(5); e.bt = 1; e.m12de = 1;               cyc(v, e, "br_taken");
    v = vz(); v.cond = 1;
    e = ez(5); e.wa3m = 9;                          cyc(v, e, "after_flush");
    v = vz();
    e = ez(5); e.wa3w = 9; e.ret = 1;               cyc(v, e, "br_w");
    v = vi(0, 0, 0, 0, 0, 0, 1);                   cyc(v, ez(6), "br2_d");
    v = vz();
    e = ez(6); e.m12de = 1;                         cyc(v, e, "br_not_taken");
    e = ez(6); e.m1em = 1; e.m2em = 1;              cyc(v, e, "r0_m");
    e = ez(6); e.m1ew = 1; e.m2ew = 1; e.ret = 1;   cyc(v, e, "r0_w");
    cyc(v, ez(7), "cnt7");

    // MOV PC with failing condition, then with passing condition
    v = vi(0, 2, 15, 1, 0, 1, 0);                  cyc(v, ez(7), "movpc_d");
    v = vz();                                       cyc(v, ez(7), "movpc_fail_e");
    e = ez(7); e.wa3m = 15;                         cyc(v, e, "movpc_fail_m");
    e = ez(7); e.wa3w = 15; e.ret = 1;              cyc(v, e, "movpc_fail_w");
    cyc(v, ez(8), "cnt8");
    v = vi(0, 2, 15, 1, 0, 1, 0);                  cyc(v, ez(8), "movpc2_d");
    v = vz(); v.cond = 1;
    e = ez(8); e.pcse = 1;                          cyc(v, e, "pcsrc_e");
    v = vz();
    e = ez(8); e.pcsm = 1; e.rwm = 1; e.wa3m = 15;  cyc(v, e, "pcsrc_m");
    e = ez(8); e.pcsw = 1; e.rww = 1; e.wa3w = 15; e.ret = 1;  cyc(v, e, "pcsrc_w");
    cyc(v, ez(9), "cnt9");

    // Stream 12 back-to-back instrs, drive the 4-bit counter into saturation
    for (int i = 0; i < 16; i++) begin
      v = (i < 12) ? vi(9, 9, 8, 0, 0, 0, 0) : vz();
      v.cond = 1;
      c = 9 + ((i < 3) ? 0 : ((i > 15) ? 12 : i - 3));
      e = ez(c);
      if (i >= 2 && i <= 13) e.wa3m = 8;
      if (i >= 3 && i <= 14) begin
        e.wa3w = 8;
        e.ret  = 1;
      end
      cyc(v, e, "stream");
    end

    // Reset while the pipe is full: everything in flight is discarded
    v = vi(9, 9, 8, 0, 0, 0, 0);                   cyc(v, ez(21), "refill0");
    cyc(v, ez(21), "refill1");
    e = ez(21); e.wa3m = 8;                         cyc(v, e, "refill2");
    v.rst_n = 1'b0;                                 cyc(v, ez(0), "mid_reset");
    v = vz();                                       cyc(v, ez(0), "post_reset0");
    cyc(v, ez(0), "post_reset1");

    for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
